// File: rtl/dino_pkg.sv
// Shared types and constants for the score keeper: FSM state encoding,
// BCD digit width and the blank code shown by the digit readout.
package dino_pkg;

    // Width of one BCD digit.
    localparam int DIGIT_W = 4;

    // One BCD digit.
    typedef logic [DIGIT_W-1:0] bcd_t;

    // Largest value a decade counter holds before it rolls over.
    localparam bcd_t BCD_NINE = 4'd9;

    // Readout code for "no digit here"; the renderer draws nothing.
    localparam bcd_t DIGIT_BLANK = 4'hF;

    // Game phases.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_OVER = 2'd2
    } state_e;

endpackage

// File: rtl/bcd_digit.sv
// One decade of the score: a 0..9 counter with synchronous clear and a
// combinational carry that ripples into the next decade.
module bcd_digit
    import dino_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic inc,
    input  logic clr,
    output bcd_t value,
    output logic carry
);

    bcd_t value_q;
    bcd_t value_d;

    // Next value: clear wins, otherwise count 0..9 and roll over.
    always_comb begin
        // NOTE: every combinational output gets a default before any branch,
        // so no path can leave it unassigned and infer a latch.
        value_d = value_q;
        if (clr) begin
            value_d = '0;
        end else if (inc) begin
            value_d = (value_q == BCD_NINE) ? '0 : value_q + 4'd1;
        end
    end

    // Digit register.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: state is written with non-blocking assignments so every
        // register samples the pre-edge values of its neighbours.
        if (!rst_n) begin
            value_q <= '0;
        end else begin
            value_q <= value_d;
        end
    end

    assign value = value_q;
    assign carry = inc & (value_q == BCD_NINE);

endmodule

// File: rtl/score_keeper.sv
// Game score accumulator: counts game ticks into a saturating BCD score
// while a game runs, keeps the high score across games, pulses on every
// hundred points and serves one digit per cycle to the renderer.
module score_keeper
    import dino_pkg::*;
#(
    parameter int TICKS_PER_POINT = 6,
    parameter int DIGITS          = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       game_tick,
    input  logic       game_start,
    input  logic       game_over,
    input  logic [3:0] i_digit_sel,
    output logic [3:0] o_digit,
    output logic       o_running,
    output logic       o_milestone,
    output logic       o_new_high
);

    // Prescaler width; a single bit is kept even when every tick is a point.
    localparam int PRE_W = (TICKS_PER_POINT > 1) ? $clog2(TICKS_PER_POINT) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICKS_PER_POINT - 1);

    // Reject parameter values the design cannot honour.
    if (TICKS_PER_POINT < 1) begin : g_bad_tpp
        $error("score_keeper: TICKS_PER_POINT must be at least 1");
    end
    if (DIGITS < 3) begin : g_bad_digits
        $error("score_keeper: DIGITS must be at least 3");
    end

    state_e           state_q;
    state_e           state_d;
    logic [PRE_W-1:0] presc_q;
    logic [PRE_W-1:0] presc_d;
    bcd_t             score [DIGITS];
    bcd_t             high_q [DIGITS];
    bcd_t             high_d [DIGITS];
    logic [DIGITS:0]  carry;
    logic             new_high_q;
    logic             new_high_d;
    logic             milestone_q;
    logic             running_q;
    bcd_t             digit_q;
    bcd_t             digit_d;

    logic in_run;
    logic start_game;
    logic end_game;
    logic point_done;
    logic all_nines;
    logic score_gt;
    logic unused_top_carry;

    assign in_run     = (state_q == ST_RUN);
    // A start only counts outside RUN; a stop only counts inside RUN.
    assign start_game = game_start && !in_run;
    assign end_game   = game_over && in_run;
    // A tick that finishes a point; dropped when the game ends on the same edge.
    assign point_done = in_run && game_tick && (presc_q == PRE_LAST) && !game_over;

    // Detect the saturated score so the increment is blocked at the chain input.
    always_comb begin
        all_nines = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (score[i] != BCD_NINE) begin
                all_nines = 1'b0;
            end
        end
    end

    assign carry[0] = point_done && !all_nines;

    // Ripple-carry decade chain, least significant digit first.
    for (genvar g = 0; g < DIGITS; g++) begin : g_digit
        bcd_digit u_digit (
            .clk   (clk),
            .rst_n (rst_n),
            .inc   (carry[g]),
            .clr   (start_game),
            .value (score[g]),
            .carry (carry[g+1])
        );
    end

    // Overflow out of the top digit cannot happen because of the saturation gate.
    assign unused_top_carry = carry[DIGITS];

    // Next game phase.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE, ST_OVER: if (game_start) state_d = ST_RUN;
            ST_RUN:           if (game_over)  state_d = ST_OVER;
            default:          state_d = ST_IDLE;
        endcase
    end

    // Game phase register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Tick prescaler: cleared on a new game, counts ticks while running.
    always_comb begin
        presc_d = presc_q;
        if (start_game) begin
            presc_d = '0;
        end else if (in_run && game_tick) begin
            presc_d = (presc_q == PRE_LAST) ? '0 : presc_q + 1'b1;
        end
    end

    // Prescaler register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q <= '0;
        end else begin
            presc_q <= presc_d;
        end
    end

    // Digit-wise magnitude compare of score against high score, MSD first.
    always_comb begin
        logic decided;
        score_gt = 1'b0;
        decided  = 1'b0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            if (!decided && (score[i] != high_q[i])) begin
                score_gt = (score[i] > high_q[i]);
                decided  = 1'b1;
            end
        end
    end

    // High score takes the final score only when it is strictly greater.
    always_comb begin
        high_d     = high_q;
        new_high_d = new_high_q;
        if (start_game) begin
            new_high_d = 1'b0;
        end else if (end_game && score_gt) begin
            high_d     = score;
            new_high_d = 1'b1;
        end
    end

    // High-score bank and its flag.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: the high score is a handful of flops, not a RAM, so the whole
        // bank is reset; a reset mid-game must wipe it as well.
        if (!rst_n) begin
            for (int i = 0; i < DIGITS; i++) begin
                high_q[i] <= '0;
            end
            new_high_q <= 1'b0;
        end else begin
            high_q     <= high_d;
            new_high_q <= new_high_d;
        end
    end

    // Readout mux: score digits, then high-score digits, then blank.
    always_comb begin
        digit_d = DIGIT_BLANK;
        for (int i = 0; i < DIGITS; i++) begin
            if (32'(i_digit_sel) == i) begin
                digit_d = score[i];
            end
            if (32'(i_digit_sel) == i + DIGITS) begin
                digit_d = high_q[i];
            end
        end
    end

    // Registered outputs: digit, running flag and hundred-point pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            digit_q     <= '0;
            running_q   <= 1'b0;
            milestone_q <= 1'b0;
        end else begin
            digit_q     <= digit_d;
            running_q   <= (state_d == ST_RUN);
            // A carry into digit 2 means the low two digits just rolled 99 -> 00.
            milestone_q <= carry[2];
        end
    end

    assign o_digit     = digit_q;
    assign o_running   = running_q;
    assign o_milestone = milestone_q;
    assign o_new_high  = new_high_q;

endmodule

// File: tb/tb_score_keeper.sv
// Bench for score_keeper: directed game sequences, a readout table and a
// randomized phase, all compared against an arithmetic model of the game.
module tb_score_keeper;

    localparam int TPP = 2;
    localparam int ND  = 4;

    logic       clk;
    logic       rst_n;
    logic       game_tick;
    logic       game_start;
    logic       game_over;
    logic [3:0] i_digit_sel;
    logic [3:0] o_digit;
    logic       o_running;
    logic       o_milestone;
    logic       o_new_high;

    score_keeper #(
        .TICKS_PER_POINT (TPP),
        .DIGITS          (ND)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .game_tick   (game_tick),
        .game_start  (game_start),
        .game_over   (game_over),
        .i_digit_sel (i_digit_sel),
        .o_digit     (o_digit),
        .o_running   (o_running),
        .o_milestone (o_milestone),
        .o_new_high  (o_new_high)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Readout table record.
    typedef struct {
        logic [3:0] sel;
        logic [3:0] exp;
    } rd_vec_t;

    typedef enum {M_IDLE, M_RUN, M_OVER} mstate_t;

    int      n_vec;
    int      n_err;
    int      mile_seen;
    int      max_score;

    // Model: score and high score as plain integers.
    mstate_t m_state;
    int      m_score;
    int      m_hi;
    int      m_ticks;
    bit      m_nh;
    bit      m_mile;

    function automatic int pow10(input int n);
        int r = 1;
        for (int i = 0; i < n; i++) r = r * 10;
        return r;
    endfunction

    function automatic logic [3:0] model_digit(input logic [3:0] sel);
        int s = int'(sel);
        if (s < ND) return 4'((m_score / pow10(s)) % 10);
        if (s < 2 * ND) return 4'((m_hi / pow10(s - ND)) % 10);
        return 4'hF;
    endfunction

    task automatic model_reset();
        m_state = M_IDLE;
        m_score = 0;
        m_hi    = 0;
        m_ticks = 0;
        m_nh    = 1'b0;
        m_mile  = 1'b0;
    endtask

    task automatic model_step(input bit tick, input bit start, input bit over);
        m_mile = 1'b0;
        if (m_state == M_RUN) begin
            if (over) begin
                m_state = M_OVER;
                if (m_score > m_hi) begin
                    m_hi = m_score;
                    m_nh = 1'b1;
                end
            end else if (tick) begin
                m_ticks++;
                if (m_ticks == TPP) begin
                    m_ticks = 0;
                    if (m_score < max_score) begin
                        m_score++;
                        if (m_score % 100 == 0) m_mile = 1'b1;
                    end
                end
            end
        end else if (start) begin
            m_state = M_RUN;
            m_score = 0;
            m_ticks = 0;
            m_nh    = 1'b0;
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock: drive inputs, advance, compare every output with the model.
    task automatic cyc(input bit tick, input bit start, input bit over, input logic [3:0] sel);
        logic [3:0] pre_digit;
        game_tick   = tick;
        game_start  = start;
        game_over   = over;
        i_digit_sel = sel;
        pre_digit   = model_digit(sel);
        @(posedge clk);
        #1;
        model_step(tick, start, over);
        if (o_milestone === 1'b1) mile_seen++;
        check("digit", 32'(o_digit), 32'(pre_digit));
        check("running", 32'(o_running), 32'(m_state == M_RUN));
        check("milestone", 32'(o_milestone), 32'(m_mile));
        check("new_high", 32'(o_new_high), 32'(m_nh));
    endtask

    task automatic add_points(input int n);
        repeat (n * TPP) cyc(1'b1, 1'b0, 1'b0, 4'd0);
    endtask

    task automatic read_digits(input string name, input int base, input int value);
        for (int s = 0; s < ND; s++) begin
            cyc(1'b0, 1'b0, 1'b0, 4'(base + s));
            check(name, 32'(o_digit), 32'((value / pow10(s)) % 10));
        end
    endtask

    initial begin
        rd_vec_t rd_tbl [11];
        rd_tbl[0]  = '{4'd0,  4'd2};
        rd_tbl[1]  = '{4'd1,  4'd1};
        rd_tbl[2]  = '{4'd2,  4'd0};
        rd_tbl[3]  = '{4'd3,  4'd0};
        rd_tbl[4]  = '{4'd4,  4'd3};
        rd_tbl[5]  = '{4'd5,  4'd4};
        rd_tbl[6]  = '{4'd6,  4'd0};
        rd_tbl[7]  = '{4'd7,  4'd0};
        rd_tbl[8]  = '{4'd8,  4'hF};
        rd_tbl[9]  = '{4'd15, 4'hF};
        rd_tbl[10] = '{4'd9,  4'hF};

        n_vec     = 0;
        n_err     = 0;
        mile_seen = 0;
        max_score = pow10(ND) - 1;
        model_reset();

        rst_n       = 1'b1;
        game_tick   = 1'b0;
        game_start  = 1'b0;
        game_over   = 1'b0;
        i_digit_sel = 4'd0;

        // Reset state.
        #3 rst_n = 1'b0;
        #20;
        check("rst_digit", 32'(o_digit), 0);
        check("rst_running", 32'(o_running), 0);
        check("rst_milestone", 32'(o_milestone), 0);
        check("rst_new_high", 32'(o_new_high), 0);
        #5 rst_n = 1'b1;

        // game_over in IDLE is ignored.
        cyc(1'b0, 1'b0, 1'b1, 4'd0);
        check("idle_over_ignored", 32'(o_running), 0);

        // Game 1: ends at 42, start mid-run is ignored.
        cyc(1'b0, 1'b1, 1'b0, 4'd0);
        check("start_running", 32'(o_running), 1);
        add_points(20);
        cyc(1'b0, 1'b1, 1'b0, 4'd0);
        add_points(22);
        cyc(1'b0, 1'b0, 1'b1, 4'd0);
        check("g1_new_high", 32'(o_new_high), 1);
        read_digits("g1_high", ND, 42);

        // Game 2: ties at 42, no new high.
        cyc(1'b0, 1'b1, 1'b0, 4'd0);
        check("g2_nh_cleared", 32'(o_new_high), 0);
        add_points(42);
        cyc(1'b0, 1'b0, 1'b1, 4'd0);
        check("g2_new_high", 32'(o_new_high), 0);
        read_digits("g2_high", ND, 42);

        // Game 3: 43 beats 42.
        cyc(1'b0, 1'b1, 1'b0, 4'd0);
        add_points(43);
        cyc(1'b0, 1'b0, 1'b1, 4'd0);
        check("g3_new_high", 32'(o_new_high), 1);
        read_digits("g3_high", ND, 43);

        // Game 4: ends at 12, then the readout table.
        cyc(1'b0, 1'b1, 1'b0, 4'd0);
        add_points(12);
        cyc(1'b0, 1'b0, 1'b1, 4'd0);
        check("g4_new_high", 32'(o_new_high), 0);
        for (int i = 0; i < 11; i++) begin
            cyc(1'b0, 1'b0, 1'b0, rd_tbl[i].sel);
            check("readout_tbl", 32'(o_digit), 32'(rd_tbl[i].exp));
        end

        // Race: completing tick with start and over together; over wins, tick dropped.
        cyc(1'b0, 1'b1, 1'b0, 4'd0);
        add_points(5);
        cyc(1'b1, 1'b0, 1'b0, 4'd0);
        cyc(1'b1, 1'b1, 1'b1, 4'd0);
        check("race_over_wins", 32'(o_running), 0);
        read_digits("race_score", 0, 5);

        // Basic counting: 10 points.
        cyc(1'b0, 1'b1, 1'b0, 4'd0);
        add_points(10);
        read_digits("basic_score", 0, 10);
        check("basic_running", 32'(o_running), 1);

        // Milestone at 100, then none for the next 99 points.
        add_points(89);
        mile_seen = 0;
        add_points(1);
        check("ms_pulse", 32'(o_milestone), 1);
        cyc(1'b0, 1'b0, 1'b0, 4'd0);
        check("ms_one_cycle", 32'(o_milestone), 0);
        check("ms_count", 32'(mile_seen), 1);
        read_digits("ms_score", 0, 100);
        mile_seen = 0;
        add_points(99);
        check("ms_none_after", 32'(mile_seen), 0);

        // Saturation at all nines.
        add_points(max_score - 199);
        read_digits("sat_reached", 0, max_score);
        mile_seen = 0;
        repeat (12) cyc(1'b1, 1'b0, 1'b0, 4'd0);
        check("sat_no_ms", 32'(mile_seen), 0);
        read_digits("sat_hold", 0, max_score);
        cyc(1'b0, 1'b0, 1'b1, 4'd0);
        check("sat_new_high", 32'(o_new_high), 1);

        // Randomized play against the model.
        repeat (3000) begin
            cyc(1'($urandom_range(0, 1)), ($urandom_range(0, 49) == 0),
                ($urandom_range(0, 99) == 0), 4'($urandom_range(0, 15)));
        end

        // Reset mid-run at score 123.
        cyc(1'b0, 1'b0, 1'b1, 4'd0);
        cyc(1'b0, 1'b1, 1'b0, 4'd0);
        add_points(123);
        cyc(1'b0, 1'b0, 1'b0, 4'd1);
        check("pre_rst_digit", 32'(o_digit), 2);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_digit", 32'(o_digit), 0);
        check("async_rst_running", 32'(o_running), 0);
        check("async_rst_milestone", 32'(o_milestone), 0);
        check("async_rst_new_high", 32'(o_new_high), 0);
        model_reset();
        #2 rst_n = 1'b1;
        cyc(1'b0, 1'b0, 1'b1, 4'd0);
        check("post_rst_idle", 32'(o_running), 0);
        cyc(1'b0, 1'b0, 1'b0, 4'd4);
        check("post_rst_high", 32'(o_digit), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
